sync_fifo_flags: RTL and testbench

//  Parametrised single-clock FIFO; next generation of the team's pointer-MSB FIFO.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/sync_fifo_flags_if.sv | 42 ++++
 rtl/fifo_ram.sv | 27 ++
 rtl/sync_fifo_flags.sv | 124 ++++++++++++
 tb/tb_sync_fifo_flags.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared read-mode constants and pointer-width helper for sync_fifo_flags
package fifo_pkg;

    // Read-mode selector values for the FWFT parameter
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Address width for a power-of-two depth; never below 1 so slices stay legal
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// rtl/sync_fifo_flags_if.sv - producer/consumer bundle for sync_fifo_flags (optional SYNC_FIFO_ERR_FLAGS_EN error flags)
// master: write/read requests and write data; slave: read data, valid, fill flags, count
interface sync_fifo_flags_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int PTR_W = ptr_width(DEPTH);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [PTR_W:0]        count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
`endif

    modport master (
        output wr_en, data_in, rd_en,
        input  data_out, valid, full, empty, almost_full, almost_empty, count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , input overflow, underflow
`endif
    );

    modport slave (
        input  wr_en, data_in, rd_en,
        output data_out, valid, full, empty, almost_full, almost_empty, count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , output overflow, underflow
`endif
    );

endinterface

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DATA_WIDTH storage, one synchronous write port, one asynchronous read port
// ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read)
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    // No reset: contents are only meaningful between the FIFO pointers
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with count, almost flags, full-with-read writes, std/FWFT read (SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow)
// ports: clk, rst (sync, active-high), bus (slave side of sync_fifo_flags_if)
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = FIFO_MODE_STD
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_flags_if.slave  bus
);

    localparam int             PTR_W    = ptr_width(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] AFULL_C  = (PTR_W + 1)'(AFULL_THRESH);
    localparam logic [PTR_W:0] AEMPTY_C = (PTR_W + 1)'(AEMPTY_THRESH);
    localparam logic [PTR_W:0] PTR_ONE  = (PTR_W + 1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [PTR_W:0]        w_ptr;
    logic [PTR_W:0]        r_ptr;
    logic [PTR_W:0]        count;
    logic                  full;
    logic                  empty;
    logic                  rd_ok;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] head;

    // Flags come from registered pointers only, so no request-to-flag path
    assign count = w_ptr - r_ptr;
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A read frees a slot in the same cycle, so a full FIFO still takes a write
    assign rd_ok = bus.rd_en & ~empty;
    assign wr_ok = bus.wr_en & (~full | rd_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (wr_ok) begin
                w_ptr <= w_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                r_ptr <= r_ptr + PTR_ONE;
            end
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (w_ptr[PTR_W-1:0]),
        .wdata (bus.data_in),
        .raddr (r_ptr[PTR_W-1:0]),
        .rdata (head)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word is presented directly; rd_en acknowledges it
            assign bus.data_out = head;
            assign bus.valid    = ~empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_q;
            logic                  valid_q;

            // data_out keeps the last word read; valid marks the cycle it arrived
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_ok;
                    if (rd_ok) begin
                        data_q <= head;
                    end
                end
            end

            assign bus.data_out = data_q;
            assign bus.valid    = valid_q;
        end
    endgenerate

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= AFULL_C);
    assign bus.almost_empty = (count <= AEMPTY_C);
    assign bus.count        = count;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_en & ~wr_ok) begin
                overflow_q <= 1'b1;
            end
            if (bus.rd_en & empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - scoreboard bench for sync_fifo_flags (standard and FWFT instances)
module tb_sync_fifo_flags;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q [$];   // words expected to appear on f0.data_out with valid
    logic [7:0] mdl   [$];   // contents the bench believes f0 holds

    sync_fifo_flags_if #(.DATA_WIDTH(8), .DEPTH(4)) f0 ();
    sync_fifo_flags_if #(.DATA_WIDTH(8), .DEPTH(4)) f1 ();

    sync_fifo_flags #(
        .DATA_WIDTH(8), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(0)
    ) dut_std (
        .clk (clk),
        .rst (rst),
        .bus (f0)
    );

    sync_fifo_flags #(
        .DATA_WIDTH(8), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(1)
    ) dut_fwft (
        .clk (clk),
        .rst (rst),
        .bus (f1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for the standard-read instance
    always @(negedge clk) begin
        if (!rst && f0.valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: got data 0x%0h expected no output", f0.data_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (f0.data_out !== e) begin
                    failures++;
                    $display("FAIL read_data: got 0x%0h expected 0x%0h", f0.data_out, e);
                end
            end
        end
    end

    // One clock of requests on f0; the bench's expectation follows the FIFO rules
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        logic r_acc;
        logic w_acc;
        r_acc = r && (mdl.size() > 0);
        w_acc = w && ((mdl.size() < 4) || r_acc);
        if (r_acc) exp_q.push_back(mdl.pop_front());
        if (w_acc) mdl.push_back(d);
        f0.wr_en   = w;
        f0.data_in = d;
        f0.rd_en   = r;
        @(posedge clk);
        #1;
        f0.wr_en = 1'b0;
        f0.rd_en = 1'b0;
    endtask

    task automatic cyc1(input logic w, input logic [7:0] d, input logic r);
        f1.wr_en   = w;
        f1.data_in = d;
        f1.rd_en   = r;
        @(posedge clk);
        #1;
        f1.wr_en = 1'b0;
        f1.rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        f0.wr_en = 1'b0; f0.rd_en = 1'b0; f0.data_in = 8'h00;
        f1.wr_en = 1'b0; f1.rd_en = 1'b0; f1.data_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_count", 32'(f0.count), 0);
        chk("rst_empty", 32'(f0.empty), 1);
        chk("rst_full", 32'(f0.full), 0);
        chk("rst_aempty", 32'(f0.almost_empty), 1);
        chk("rst_afull", 32'(f0.almost_full), 0);
        chk("rst_valid", 32'(f0.valid), 0);
        chk("rst_data", 32'(f0.data_out), 0);
        chk("rst_fwft_valid", 32'(f1.valid), 0);

        // 1: fill to full, then one dropped write
        cyc(1, 8'hA0, 0);
        chk("t1_count1", 32'(f0.count), 1);
        chk("t1_aempty1", 32'(f0.almost_empty), 1);
        cyc(1, 8'hA1, 0);
        chk("t1_count2", 32'(f0.count), 2);
        chk("t1_aempty2", 32'(f0.almost_empty), 0);
        chk("t1_afull2", 32'(f0.almost_full), 0);
        cyc(1, 8'hA2, 0);
        chk("t1_count3", 32'(f0.count), 3);
        chk("t1_afull3", 32'(f0.almost_full), 1);
        chk("t1_full3", 32'(f0.full), 0);
        cyc(1, 8'hA3, 0);
        chk("t1_count4", 32'(f0.count), 4);
        chk("t1_full4", 32'(f0.full), 1);
        cyc(1, 8'hA4, 0);
        chk("t1_drop_count", 32'(f0.count), 4);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("t1_overflow", 32'(f0.overflow), 1);
`endif

        // 2: drain A0..A3, then read while empty
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 1);
        chk("t2_not_empty", 32'(f0.empty), 0);
        cyc(0, 8'h00, 1);
        chk("t2_empty", 32'(f0.empty), 1);
        chk("t2_last", 32'(f0.data_out), 32'h A3);
        cyc(0, 8'h00, 1);
        chk("t2_hold_data", 32'(f0.data_out), 32'h A3);
        chk("t2_hold_valid", 32'(f0.valid), 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("t2_underflow", 32'(f0.underflow), 1);
`endif

        // 3: write+read while full
        cyc(1, 8'hB0, 0);
        cyc(1, 8'hB1, 0);
        cyc(1, 8'hB2, 0);
        cyc(1, 8'hB3, 0);
        cyc(1, 8'h55, 1);
        chk("t3_count", 32'(f0.count), 4);
        chk("t3_full", 32'(f0.full), 1);
        chk("t3_head", 32'(f0.data_out), 32'h B0);
        repeat (4) cyc(0, 8'h00, 1);
        chk("t3_last", 32'(f0.data_out), 32'h 55);
        chk("t3_empty", 32'(f0.empty), 1);

        // 4: write+read while empty -> write only
        cyc(1, 8'h11, 1);
        chk("t4_count", 32'(f0.count), 1);
        chk("t4_valid", 32'(f0.valid), 0);
        cyc(0, 8'h00, 1);
        chk("t4_data", 32'(f0.data_out), 32'h 11);

        // 5: fall-through instance
        cyc1(1, 8'h7E, 0);
        chk("t5_valid", 32'(f1.valid), 1);
        chk("t5_data", 32'(f1.data_out), 32'h 7E);
        cyc1(1, 8'h01, 0);
        chk("t5_count", 32'(f1.count), 2);
        chk("t5_head_hold", 32'(f1.data_out), 32'h 7E);
        cyc1(0, 8'h00, 1);
        chk("t5_pop_data", 32'(f1.data_out), 32'h 01);
        chk("t5_pop_valid", 32'(f1.valid), 1);
        cyc1(0, 8'h00, 1);
        chk("t5_empty_valid", 32'(f1.valid), 0);
        chk("t5_empty", 32'(f1.empty), 1);

        // 6: reset in the middle of a 3-word burst
        cyc(1, 8'hC0, 0);
        cyc(1, 8'hC1, 0);
        f0.wr_en   = 1'b1;
        f0.data_in = 8'hC2;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        f0.wr_en = 1'b0;
        mdl.delete();
        exp_q.delete();
        chk("t6_count", 32'(f0.count), 0);
        chk("t6_empty", 32'(f0.empty), 1);
        chk("t6_full", 32'(f0.full), 0);
        chk("t6_valid", 32'(f0.valid), 0);
        chk("t6_aempty", 32'(f0.almost_empty), 1);
        chk("t6_afull", 32'(f0.almost_full), 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("t6_overflow", 32'(f0.overflow), 0);
        chk("t6_underflow", 32'(f0.underflow), 0);
`endif
        // Ten words streamed through so both pointers pass the wrap bit
        cyc(1, 8'hD0, 0);
        for (int i = 1; i < 10; i++) begin
            cyc(1, 8'(8'hD0 + i), 1);
        end
        chk("t6_stream_count", 32'(f0.count), 1);
        cyc(0, 8'h00, 1);
        chk("t6_wrap_last", 32'(f0.data_out), 32'h D9);
        chk("t6_final_empty", 32'(f0.empty), 1);

        repeat (2) @(posedge clk);
        #1;
        chk("pending_reads", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
